// File: rtl/execute_memory.sv
// Execute + memory stage of the Y86-64 sequential core: ALU, condition codes, and a
// word-organised data memory behind a multi-cycle IDLE/EXEC/MEM/DONE access FSM.
module execute_memory #(
    parameter int unsigned n       = 64,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [n-1:0] valA,
    input  logic [n-1:0] valB,
    input  logic [n-1:0] valC,
    input  logic [n-1:0] valP,
    output logic [n-1:0] valE,
    output logic [n-1:0] valM,
    output logic         Cnd,
    output logic [2:0]   cc,
    output logic         busy,
    output logic         done,
    output logic         dmem_error
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [n-1:0] MemBytes = n'(64'(DEPTH) * 64'd8);
    localparam logic [n-1:0] Eight    = n'(8);
    localparam logic [CW-1:0] CntInit = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StExec, StMem, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  vale_q, valm_q;
    logic          cnd_q, dmem_error_q;
    logic [2:0]    cc_q;

    logic [n-1:0]  alu;
    logic          of_new;
    logic          cond;
    logic          is_mem, is_write;
    logic [n-1:0]  mem_addr, wdata;
    logic          addr_err;
    logic [AW-1:0] mem_idx;
    logic          mem_last, mem_we;

    logic [n-1:0]  mem [DEPTH];

    // ALU and overflow for OPq
    always_comb begin
        alu    = '0;
        of_new = 1'b0;
        case (icode)
            4'h2: alu = valA;
            4'h3: alu = valC;
            4'h4, 4'h5: alu = valB + valC;
            4'h6: begin
                case (ifun)
                    4'h0: begin
                        alu    = valB + valA;
                        of_new = (valA[n-1] == valB[n-1]) && (alu[n-1] != valB[n-1]);
                    end
                    4'h1: begin
                        alu    = valB - valA;
                        of_new = (valA[n-1] != valB[n-1]) && (alu[n-1] != valB[n-1]);
                    end
                    4'h2: alu = valB & valA;
                    4'h3: alu = valB ^ valA;
                    default: alu = '0;
                endcase
            end
            4'h8, 4'hA: alu = valB - Eight;
            4'h9, 4'hB: alu = valB + Eight;
            default: alu = '0;
        endcase
    end

    // Condition evaluated against the flags from before this instruction
    always_comb begin
        cond = 1'b0;
        case (ifun)
            4'h0: cond = 1'b1;
            4'h1: cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2: cond = cc_q[1] ^ cc_q[0];
            4'h3: cond = cc_q[2];
            4'h4: cond = ~cc_q[2];
            4'h5: cond = ~(cc_q[1] ^ cc_q[0]);
            4'h6: cond = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        is_mem   = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                   (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);
        is_write = (icode == 4'h4) || (icode == 4'h8) || (icode == 4'hA);
        // valE is already registered by the time MEM runs; inputs are held stable
        mem_addr = ((icode == 4'h9) || (icode == 4'hB)) ? valA : vale_q;
        wdata    = (icode == 4'h8) ? valP : valA;
        addr_err = (mem_addr[2:0] != 3'b000) || (mem_addr >= MemBytes);
        mem_idx  = mem_addr[AW+2:3];
        mem_last = (state_q == StMem) && (cnt_q == '0);
        mem_we   = mem_last && is_write && !addr_err;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: if (start) state_d = StExec;
            StExec: begin
                if (is_mem) begin
                    state_d = StMem;
                    cnt_d   = CntInit;
                end else begin
                    state_d = StDone;
                end
            end
            StMem: begin
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vale_q       <= '0;
            valm_q       <= '0;
            cnd_q        <= 1'b0;
            dmem_error_q <= 1'b0;
            cc_q         <= 3'b100;
        end else begin
            if (state_q == StExec) begin
                vale_q       <= alu;
                cnd_q        <= ((icode == 4'h2) || (icode == 4'h7)) ? cond : 1'b0;
                dmem_error_q <= 1'b0;
                if (icode == 4'h6) cc_q <= {(alu == '0), alu[n-1], of_new};
            end
            if (mem_last) begin
                if (addr_err) begin
                    valm_q       <= '0;
                    dmem_error_q <= 1'b1;
                end else if (!is_write) begin
                    valm_q <= mem[mem_idx];
                end
            end
        end
    end

    // No reset on the array; an async reset moves state out of MEM so mem_we drops
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= wdata;
    end

    assign valE       = vale_q;
    assign valM       = valm_q;
    assign Cnd        = cnd_q;
    assign cc         = cc_q;
    assign dmem_error = dmem_error_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_execute_memory.sv
// Directed bench for execute_memory: ALU/CC/Cnd, memory round trips, address errors,
// reset abort during MEM and start-while-busy handling.
module tb_execute_memory;

    localparam int unsigned MemLat = 2;

    logic        clk, rst_n, start;
    logic [3:0]  icode, ifun;
    logic [63:0] valA, valB, valC, valP;
    logic [63:0] valE, valM;
    logic        Cnd, busy, done, dmem_error;
    logic [2:0]  cc;

    int errors = 0;
    int checks = 0;
    int lat;
    int pulses;

    execute_memory #(.n(64), .DEPTH(256), .MEM_LAT(MemLat)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .ifun(ifun),
        .valA(valA), .valB(valB), .valC(valC), .valP(valP),
        .valE(valE), .valM(valM), .Cnd(Cnd), .cc(cc), .busy(busy), .done(done),
        .dmem_error(dmem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one instruction and wait (bounded) for done; returns cycles from start edge.
    task automatic run(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [63:0] p,
                       output int cycles);
        @(negedge clk);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c; valP = p;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1 cycles++;
        end
        check("done_seen", done, 1'b1);
        @(posedge clk);
        #1 check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0; valP = '0;
        repeat (2) @(negedge clk);
        check("rst_valE", valE, 64'h0);
        check("rst_valM", valM, 64'h0);
        check("rst_Cnd", Cnd, 1'b0);
        check("rst_cc", cc, 3'b100);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dmem_error", dmem_error, 1'b0);
        rst_n = 1'b1;

        // OPq sub: 3 - 5
        run(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 64'd0, lat);
        check("sub_lat", lat, 1);
        check("sub_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_cc", cc, 3'b010);

        // OPq add overflow, then conditional moves reading those flags
        run(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, lat);
        check("add_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_cc", cc, 3'b011);
        run(4'h2, 4'h2, 64'h99, 64'd0, 64'd0, 64'd0, lat);
        check("cmovl_Cnd", Cnd, 1'b0);
        check("cmovl_valE", valE, 64'h99);
        check("cmovl_cc_kept", cc, 3'b011);
        run(4'h2, 4'h5, 64'h77, 64'd0, 64'd0, 64'd0, lat);
        check("cmovge_Cnd", Cnd, 1'b1);
        run(4'h6, 4'h3, 64'h5, 64'h5, 64'd0, 64'd0, lat);
        check("xor_valE", valE, 64'h0);
        check("xor_cc", cc, 3'b100);
        check("xor_Cnd", Cnd, 1'b0);

        // pushq / popq round trip
        run(4'hA, 4'h0, 64'h1234, 64'h40, 64'd0, 64'd0, lat);
        check("push_lat", lat, 1 + MemLat);
        check("push_valE", valE, 64'h38);
        check("push_err", dmem_error, 1'b0);
        run(4'hB, 4'h0, 64'h38, 64'h38, 64'd0, 64'd0, lat);
        check("pop_lat", lat, 1 + MemLat);
        check("pop_valM", valM, 64'h1234);
        check("pop_valE", valE, 64'h40);

        // Misaligned read, then error cleared by a non-memory op
        run(4'h5, 4'h0, 64'd0, 64'd1, 64'd2, 64'd0, lat);
        check("misal_lat", lat, 1 + MemLat);
        check("misal_err", dmem_error, 1'b1);
        check("misal_valM", valM, 64'h0);
        check("misal_valE", valE, 64'h3);
        run(4'h3, 4'h0, 64'd0, 64'd0, 64'd7, 64'd0, lat);
        check("irmov_err_clr", dmem_error, 1'b0);
        check("irmov_valE", valE, 64'h7);

        // Good read makes valM nonzero, out-of-range read zeroes it
        run(4'h5, 4'h0, 64'd0, 64'h30, 64'h8, 64'd0, lat);
        check("mr_valM", valM, 64'h1234);
        run(4'h5, 4'h0, 64'd0, 64'd2048, 64'd0, 64'd0, lat);
        check("oor_lat", lat, 1 + MemLat);
        check("oor_err", dmem_error, 1'b1);
        check("oor_valM", valM, 64'h0);

        // call writes valP, read back
        run(4'h8, 4'h0, 64'd0, 64'h88, 64'd0, 64'hCAFE, lat);
        check("call_valE", valE, 64'h80);
        check("call_valM_kept", valM, 64'h0);
        run(4'h5, 4'h0, 64'd0, 64'h80, 64'd0, 64'd0, lat);
        check("call_readback", valM, 64'hCAFE);

        // Prior value at 0x10, set flags, then a write aborted by reset during MEM
        run(4'h4, 4'h0, 64'h55, 64'h10, 64'd0, 64'd0, lat);
        run(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 64'd0, lat);
        @(negedge clk);
        icode = 4'h4; ifun = 4'h0; valA = 64'hAA; valB = 64'h10; valC = 64'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 check("abort_busy_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valE", valE, 64'h0);
        check("abort_valM", valM, 64'h0);
        check("abort_Cnd", Cnd, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_cc", cc, 3'b100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'h5, 4'h0, 64'd0, 64'h10, 64'd0, 64'd0, lat);
        check("abort_no_write", valM, 64'h55);

        // start pulsed while busy is ignored: exactly one done
        @(negedge clk);
        icode = 4'h5; ifun = 4'h0; valA = 64'd0; valB = 64'h38; valC = 64'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        check("busy_start_pulses", pulses, 1);
        check("busy_start_idle", busy, 1'b0);
        check("busy_start_valM", valM, 64'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
